// File: rtl/lcd_capture.sv
// Responder end of a 4-bit HD44780-style character-LCD bus: it rebuilds bytes from nibble strobes and keeps a 2x16 frame image.
// Define LCD_CAPTURE_READ_EN to enable busy-flag/address read-back; without it rw=1 strobes are ignored.
module lcd_capture #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [3:0]   lcd_dat,
  output logic [3:0]   lcd_dat_o,
  output logic         lcd_dat_oe,
  output logic [255:0] frame,
  output logic [4:0]   cursor,
  output logic         mode4,
  output logic         wr_pulse,
  output logic         cmd_pulse,
  output logic [7:0]   cmd_code
);

  typedef enum logic [1:0] {
    PH_INIT = 2'd0,
    PH_HIGH = 2'd1,
    PH_LOW  = 2'd2
  } phase_t;

  logic [SYNC_STAGES-1:0]      eSync_q;
  logic [SYNC_STAGES-1:0]      rsSync_q;
  logic [SYNC_STAGES-1:0]      rwSync_q;
  logic [SYNC_STAGES-1:0][3:0] datSync_q;
  logic                        ePrev_q;

  logic       eS, rsS, rwS;
  logic [3:0] datS;
  logic       fallSeen;

  logic       stbValid_q;
  logic       stbRs_q;
  logic       stbRw_q;
  logic [3:0] stbDat_q;

  phase_t     state_q, state_d;
  logic [4:0] cursor_q, cursor_d;
  logic [7:0] cmdCode_q, cmdCode_d;
  logic [3:0] hiNib_q, hiNib_d;
  logic       wrPulse_q, wrPulse_d;
  logic       cmdPulse_q, cmdPulse_d;
  logic       clearFrame;
  logic       writeChar;
  logic [7:0] byteVal;

  logic [7:0] chars_q [32];

  assign eS   = eSync_q[SYNC_STAGES-1];
  assign rsS  = rsSync_q[SYNC_STAGES-1];
  assign rwS  = rwSync_q[SYNC_STAGES-1];
  assign datS = datSync_q[SYNC_STAGES-1];
  assign fallSeen = ePrev_q & ~eS;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eSync_q   <= '0;
      rsSync_q  <= '0;
      rwSync_q  <= '0;
      datSync_q <= '0;
      ePrev_q   <= 1'b0;
    end else begin
      eSync_q   <= {eSync_q[SYNC_STAGES-2:0], lcd_e};
      rsSync_q  <= {rsSync_q[SYNC_STAGES-2:0], lcd_rs};
      rwSync_q  <= {rwSync_q[SYNC_STAGES-2:0], lcd_rw};
      datSync_q <= {datSync_q[SYNC_STAGES-2:0], lcd_dat};
      ePrev_q   <= eS;
    end
  end

  // Bus fields are frozen from the same sync stage that revealed the falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stbValid_q <= 1'b0;
      stbRs_q    <= 1'b0;
      stbRw_q    <= 1'b0;
      stbDat_q   <= 4'h0;
    end else begin
      stbValid_q <= fallSeen;
      if (fallSeen) begin
        stbRs_q  <= rsS;
        stbRw_q  <= rwS;
        stbDat_q <= datS;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    cmdCode_d  = cmdCode_q;
    hiNib_d    = hiNib_q;
    wrPulse_d  = 1'b0;
    cmdPulse_d = 1'b0;
    clearFrame = 1'b0;
    writeChar  = 1'b0;
    byteVal    = {hiNib_q, stbDat_q};
    if (stbValid_q && !stbRw_q) begin
      case (state_q)
        PH_INIT: begin
          if (!stbRs_q) begin
            cmdCode_d  = {stbDat_q, 4'h0};
            cmdPulse_d = 1'b1;
            if (stbDat_q == 4'h2) state_d = PH_HIGH;
          end
        end
        PH_HIGH: begin
          hiNib_d = stbDat_q;
          state_d = PH_LOW;
        end
        PH_LOW: begin
          state_d = PH_HIGH;
          if (stbRs_q) begin
            writeChar = 1'b1;
            wrPulse_d = 1'b1;
            cursor_d  = cursor_q + 5'd1;
          end else begin
            cmdPulse_d = 1'b1;
            cmdCode_d  = byteVal;
            if (byteVal == 8'h01) begin
              clearFrame = 1'b1;
              cursor_d   = 5'd0;
            end else if (byteVal[7:1] == 7'b0000001) begin
              cursor_d = 5'd0;
            end else if (byteVal[7]) begin
              // Only the first 16 addresses of each DDRAM line map onto the frame.
              if (byteVal[6:4] == 3'b000)      cursor_d = {1'b0, byteVal[3:0]};
              else if (byteVal[6:4] == 3'b100) cursor_d = {1'b1, byteVal[3:0]};
            end
          end
        end
        default: state_d = PH_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PH_INIT;
      cursor_q   <= 5'd0;
      cmdCode_q  <= 8'h00;
      hiNib_q    <= 4'h0;
      wrPulse_q  <= 1'b0;
      cmdPulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cursor_q   <= cursor_d;
      cmdCode_q  <= cmdCode_d;
      hiNib_q    <= hiNib_d;
      wrPulse_q  <= wrPulse_d;
      cmdPulse_q <= cmdPulse_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) chars_q[i] <= BLANK_CHAR;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (clearFrame)                            chars_q[i] <= BLANK_CHAR;
        else if (writeChar && cursor_q == 5'(i))   chars_q[i] <= byteVal;
      end
    end
  end

  for (genvar g = 0; g < 32; g++) begin : gFrame
    assign frame[255-8*g -: 8] = chars_q[g];
  end

  assign cursor    = cursor_q;
  assign mode4     = (state_q != PH_INIT);
  assign wr_pulse  = wrPulse_q;
  assign cmd_pulse = cmdPulse_q;
  assign cmd_code  = cmdCode_q;

`ifdef LCD_CAPTURE_READ_EN
  logic       readPhase_q;
  logic [6:0] addrCounter;

  // Read phase selects which AC nibble is returned; any write restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            readPhase_q <= 1'b0;
    else if (stbValid_q) readPhase_q <= stbRw_q ? ~readPhase_q : 1'b0;
  end

  assign addrCounter = cursor_q[4] ? {3'b100, cursor_q[3:0]} : {3'b000, cursor_q[3:0]};

  always_comb begin
    lcd_dat_oe = eS & rwS & ~rsS;
    lcd_dat_o  = 4'h0;
    if (lcd_dat_oe) lcd_dat_o = readPhase_q ? addrCounter[3:0] : {1'b0, addrCounter[6:4]};
  end
`else
  assign lcd_dat_o  = 4'h0;
  assign lcd_dat_oe = 1'b0;
`endif

endmodule
